// File: rtl/lsu_mem_port.sv
// Load/store initiator for a single-port word RAM with registered read data.
// Optional build macro LSU_RANGE_CHK_EN rejects addresses beyond the 2^MEM_AW-word RAM with err=11.
module lsu_mem_port #(
    parameter int unsigned MEM_AW    = 16,
    parameter logic [31:0] RESET_ADR = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_d,
    output logic        mem_we,
    output logic [1:0]  mem_store_type,
    output logic [1:0]  mem_store_offset,
    input  logic [31:0] mem_q
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA, RESP} state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_F3    = 2'b10;
    localparam logic [1:0] ERR_RANGE = 2'b11;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;
    logic        out_of_range;

    function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
        if (we) return !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] q);
        logic [7:0]  b;
        logic [15:0] h;
        b = q[8*off +: 8];
        h = off[1] ? q[31:16] : q[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return q;
        endcase
    endfunction

    assign out_of_range = (req_addr >> (MEM_AW + 2)) != 32'd0;

`ifndef LSU_RANGE_CHK_EN
    // Without range checking the RAM simply wraps on its own index bits.
    logic unused_range;
    assign unused_range = out_of_range;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = ERR_OK;
                    state_d = RESP;
                    if (illegal_f3(req_we, req_funct3)) begin
                        err_d = ERR_F3;
                    end else if (misaligned(req_funct3, req_addr[1:0])) begin
                        err_d = ERR_ALIGN;
`ifdef LSU_RANGE_CHK_EN
                    end else if (out_of_range) begin
                        err_d = ERR_RANGE;
`endif
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = we_q ? RESP : DATA;
            DATA: begin
                rdata_d = load_extract(f3_q, addr_q[1:0], mem_q);
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            rdata_q <= 32'h0;
            err_q   <= ERR_OK;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            we_q    <= we_d;
        end
    end

    // Request payload needs no reset: it is only observed after a fresh latch in IDLE.
    always_ff @(posedge CLK) begin
        f3_q    <= f3_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign req_ready        = (state_q == IDLE) && !RST;
    assign resp_valid       = (state_q == RESP);
    assign resp_rdata       = rdata_q;
    assign resp_err         = err_q;
    assign mem_d            = wdata_q;
    assign mem_we           = (state_q == ISSUE) && we_q && !RST;
    assign mem_store_offset = addr_q[1:0];
    assign mem_adr          = (state_q == ISSUE || state_q == DATA) ? {2'b00, addr_q[31:2]}
                                                                    : RESET_ADR;

    always_comb begin
        mem_store_type = 2'b00;
        if (state_q == ISSUE && we_q) begin
            case (f3_q[1:0])
                2'b00:   mem_store_type = 2'b01;
                2'b01:   mem_store_type = 2'b10;
                default: mem_store_type = 2'b11;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: a behavioural RAM plus a byte-array reference model.
module tb_lsu_mem_port;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] mem_adr;
    logic [31:0] mem_d;
    logic        mem_we;
    logic [1:0]  mem_store_type;
    logic [1:0]  mem_store_offset;
    logic [31:0] mem_q;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ram [1024];
    logic [7:0]  ref_mem [4096];

    always #5 CLK = ~CLK;

    lsu_mem_port #(.MEM_AW(16), .RESET_ADR(32'h0)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_adr(mem_adr), .mem_d(mem_d), .mem_we(mem_we),
        .mem_store_type(mem_store_type), .mem_store_offset(mem_store_offset),
        .mem_q(mem_q)
    );

    // RAM: word indexed, lane-selecting writes, registered read
    always @(posedge CLK) begin
        if (mem_we) begin
            case (mem_store_type)
                2'b01: ram[mem_adr[9:0]][8*mem_store_offset +: 8] = mem_d[7:0];
                2'b10: ram[mem_adr[9:0]][16*mem_store_offset[1] +: 16] = mem_d[15:0];
                2'b11: ram[mem_adr[9:0]] = mem_d;
                default: ;
            endcase
        end
        mem_q <= ram[mem_adr[9:0]];
    end

    task automatic set_word(input int idx, input logic [31:0] w);
        ram[idx] = w;
        for (int b = 0; b < 4; b++) ref_mem[idx*4 + b] = w[8*b +: 8];
    endtask

    // Reference: expected response computed from the ISA rules on a flat byte array
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] er,
                         output int lat);
        int size;
        int a;
        logic legal;
        legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = 1 << f3[1:0];
        a = int'(addr & 32'hFFF);
        rd = 32'h0;
        er = 2'b00;
        lat = we ? 2 : 3;
        if (!legal) begin
            er = 2'b10; lat = 1;
        end else if ((addr % size) != 0) begin
            er = 2'b01; lat = 1;
`ifdef LSU_RANGE_CHK_EN
        end else if (addr >= 32'h0004_0000) begin
            er = 2'b11; lat = 1;
`endif
        end else if (we) begin
            for (int b = 0; b < size; b++) ref_mem[a + b] = wd[8*b +: 8];
        end else begin
            if (size == 1) rd = (f3 == 3'd0) ? 32'($signed(ref_mem[a])) : {24'h0, ref_mem[a]};
            else if (size == 2) rd = (f3 == 3'd1) ? 32'($signed({ref_mem[a+1], ref_mem[a]}))
                                                  : {16'h0, ref_mem[a+1], ref_mem[a]};
            else rd = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        end
    endtask

    // Drives one request and collects what the DUT did; lat counts edges from acceptance (inclusive).
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic [1:0] er, output int lat,
                        output int wecnt, output logic [31:0] iss_adr, output logic [1:0] iss_st,
                        output logic [1:0] iss_off, output int unstable);
        int guard;
        @(negedge CLK);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        wecnt = mem_we ? 1 : 0;
        iss_adr = mem_adr; iss_st = mem_store_type; iss_off = mem_store_offset;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
            if (mem_we) wecnt++;
        end
        if (!resp_valid) lat = -1;
        rd = resp_rdata; er = resp_err; unstable = 0;
        repeat (hold) begin
            @(posedge CLK);
            #1;
            if (!resp_valid || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0) unstable++;
        end
        resp_ready = 1'b1;
        @(posedge CLK);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_vec++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_we !== 1'b0 || mem_adr !== 32'h0 ||
            mem_store_type !== 2'b00 || resp_rdata !== 32'h0 || resp_err !== 2'b00) begin
            n_err++;
            $display("FAIL reset_state: ready=%b valid=%b we=%b adr=%h st=%b rdata=%h err=%b, required 0 0 0 0 0 0 0",
                     req_ready, resp_valid, mem_we, mem_adr, mem_store_type, resp_rdata, resp_err);
        end
        RST = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  f3s  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [31:0] adrs [5] = '{32'h100, 32'h101, 32'h102, 32'h102, 32'h100};
        logic [31:0] exps [5] = '{32'hFFFF_FFF2, 32'h0000_007F, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_7FF2};
        logic [31:0] rd, ia;
        logic [1:0]  er, st, off;
        int lat, wc, us;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, f3s[i], adrs[i], 32'h0, 0, rd, er, lat, wc, ia, st, off, us);
            n_vec++;
            if (rd !== exps[i] || er !== 2'b00 || lat != 3 || wc != 0) begin
                n_err++;
                $display("FAIL load_%0d: rdata=%h err=%b lat=%0d we=%0d, required %h 00 3 0",
                         i, rd, er, lat, wc, exps[i]);
            end
        end
    endtask

    task automatic test_store_byte;
        logic [31:0] rd, ia, old, e_rd;
        logic [1:0]  er, st, off, e_er;
        int lat, wc, us, e_lat;
        old = {ref_mem[12'h203], ref_mem[12'h202], ref_mem[12'h201], ref_mem[12'h200]};
        model(1'b1, 3'd0, 32'h203, 32'h0000_00AB, e_rd, e_er, e_lat);
        send(1'b1, 3'd0, 32'h203, 32'h0000_00AB, 0, rd, er, lat, wc, ia, st, off, us);
        n_vec++;
        if (st !== 2'b01 || off !== 2'b11 || ia !== 32'h80 || wc != 1 || er !== 2'b00 ||
            rd !== 32'h0 || lat != 2) begin
            n_err++;
            $display("FAIL sb_issue: st=%b off=%b adr=%h we=%0d err=%b rdata=%h lat=%0d, required 01 11 80 1 00 0 2",
                     st, off, ia, wc, er, rd, lat);
        end
        send(1'b0, 3'd2, 32'h200, 32'h0, 0, rd, er, lat, wc, ia, st, off, us);
        n_vec++;
        if (rd !== {8'hAB, old[23:0]} || er !== 2'b00) begin
            n_err++;
            $display("FAIL sb_readback: rdata=%h err=%b, required %h 00", rd, er, {8'hAB, old[23:0]});
        end
    endtask

    task automatic test_errors;
        logic        wes  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s  [4] = '{3'd1, 3'd3, 3'd4, 3'd2};
        logic [31:0] adrs [4] = '{32'h101, 32'h100, 32'h100, 32'h202};
        logic [1:0]  exps [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
        logic [31:0] rd, ia;
        logic [1:0]  er, st, off;
        int lat, wc, us;
        for (int i = 0; i < 4; i++) begin
            send(wes[i], f3s[i], adrs[i], 32'hDEAD_BEEF, 0, rd, er, lat, wc, ia, st, off, us);
            n_vec++;
            if (er !== exps[i] || rd !== 32'h0 || lat != 1 || wc != 0) begin
                n_err++;
                $display("FAIL err_%0d: err=%b rdata=%h lat=%0d we=%0d, required %b 0 1 0",
                         i, er, rd, lat, wc, exps[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd, ia, e_rd;
        logic [1:0]  er, st, off, e_er;
        int lat, wc, us, e_lat;
        model(1'b0, 3'd2, 32'h100, 32'h0, e_rd, e_er, e_lat);
        send(1'b0, 3'd2, 32'h100, 32'h0, 5, rd, er, lat, wc, ia, st, off, us);
        n_vec++;
        if (us != 0 || rd !== e_rd || er !== e_er) begin
            n_err++;
            $display("FAIL backpressure: unstable=%0d rdata=%h err=%b, required 0 %h %b", us, rd, er, e_rd, e_er);
        end
    endtask

    task automatic test_reset_in_data;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0 || mem_adr !== 32'h0 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_data: valid=%b ready=%b adr=%h we=%b, required 0 0 0 0",
                     resp_valid, req_ready, mem_adr, mem_we);
        end
        RST = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_data_release: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_range;
        logic [31:0] rd, ia, e_rd;
        logic [1:0]  er, st, off, e_er;
        int lat, wc, us, e_lat;
        model(1'b0, 3'd2, 32'h0004_0000, 32'h0, e_rd, e_er, e_lat);
        send(1'b0, 3'd2, 32'h0004_0000, 32'h0, 0, rd, er, lat, wc, ia, st, off, us);
        n_vec++;
        if (rd !== e_rd || er !== e_er || lat != e_lat || wc != 0) begin
            n_err++;
            $display("FAIL range: rdata=%h err=%b lat=%0d we=%0d, required %h %b %0d 0",
                     rd, er, lat, wc, e_rd, e_er, e_lat);
        end
`ifndef LSU_RANGE_CHK_EN
        n_vec++;
        if (ia !== 32'h0001_0000) begin
            n_err++;
            $display("FAIL range_adr: mem_adr=%h, required 00010000", ia);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [2:0]  legal_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
        logic [31:0] rd, ia, e_rd, addr, wd;
        logic [1:0]  er, st, off, e_er;
        logic [2:0]  f3;
        logic        we;
        int lat, wc, us, e_lat;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 7)] : 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            wd = $urandom;
            model(we, f3, addr, wd, e_rd, e_er, e_lat);
            send(we, f3, addr, wd, 0, rd, er, lat, wc, ia, st, off, us);
            n_vec++;
            if (rd !== e_rd || er !== e_er || lat != e_lat || wc != ((e_er == 2'b00 && we) ? 1 : 0)) begin
                n_err++;
                $display("FAIL rand_%0d (we=%b f3=%0d addr=%h): rdata=%h err=%b lat=%0d we_cnt=%0d, required %h %b %0d",
                         i, we, f3, addr, rd, er, lat, wc, e_rd, e_er, e_lat);
            end
        end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        resp_ready = 1'b0; RST = 1'b1;
        for (int i = 0; i < 1024; i++) set_word(i, $urandom);
        set_word(32'h40, 32'h8001_7FF2);
        test_reset();
        test_loads();
        test_store_byte();
        test_errors();
        test_backpressure();
        test_reset_in_data();
        test_range();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
Load/store initiator that drives the single-port data RAM (ccm-style word array: word-indexed ADR, D, WE, 2-bit store_type/store_offset, registered Q) on behalf of the RV32I core.
- Accepts one core memory request at a time.
- Issues RAM read or partial-write cycles.
- Extracts and sign/zero-extends load data.
- Returns a response over a valid/ready handshake, with error reporting for misaligned or illegal accesses.

Parameters:
- MEM_AW, 16, log2 of RAM depth in words (RAM holds 2^MEM_AW words).
- RESET_ADR, 32'h0, value driven on mem_adr while idle or in reset.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- req_valid  input  1  core request valid.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response valid.
- resp_ready  input  1  core accepts response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 out of range.
- mem_adr  output  32  word address = {2'b0, addr[31:2]}.
- mem_d  output  32  store data, unshifted (RAM selects lanes).
- mem_we  output  1  RAM write enable.
- mem_store_type  output  2  SW 2'b11, SH 2'b10, SB 2'b01; 2'b00 on loads.
- mem_store_offset  output  2  addr[1:0].
- mem_q  input  32  RAM read data, valid the cycle after a read edge.

Behaviour:
- Reset: state IDLE, req_ready=0 during RST, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_adr=RESET_ADR, mem_store_type=0. mem_we is gated by !RST. An in-flight request and any pending response are discarded.
- States: IDLE, ISSUE, DATA, RESP.
- IDLE: req_ready=1. On req_valid, latch we, funct3, addr, wdata, then check in order:
  - illegal funct3 (load 011/110/111; store anything other than 000/001/010) gives err=10;
  - misaligned (half with addr[0]=1, word with addr[1:0]!=0) gives err=01.
  - On error go to RESP with rdata=0 and no RAM access; otherwise go to ISSUE.
- ISSUE: drive mem_adr. For a store: mem_we=1, mem_d=wdata, mem_store_type from funct3, mem_store_offset=addr[1:0], then go to RESP with err=00, rdata=0. For a load: mem_we=0, go to DATA.
- DATA: mem_q holds the word. Extract:
  - byte = mem_q[8*off +: 8];
  - half = off[1] ? mem_q[31:16] : mem_q[15:0];
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Register into resp_rdata and go to RESP.
- RESP: resp_valid=1; resp_rdata/resp_err held stable until resp_valid && resp_ready, then go to IDLE. req_ready=0 here.
- Latency from acceptance edge to resp_valid high:
  - load: 3 cycles;
  - store: 2 cycles;
  - error: 1 cycle.
- Outside ISSUE: mem_we=0 and mem_store_type=0. mem_adr holds the latched word address from ISSUE through DATA.
- No request overlap. A new request is accepted only in IDLE, so the earliest is the cycle after the response handshake.
- Byte lanes: little-endian; offset 0 is bits [7:0].

Optional Feature:
LSU_RANGE_CHK_EN
- Defined: in IDLE, after the funct3 and alignment checks, any request with addr[31:MEM_AW+2] != 0 returns err=11 after 1 cycle with no RAM access.
- Undefined: no range check; mem_adr is driven from the full addr[31:2] and the RAM's own indexing applies.

Test Plan:
- Preload word 0x40 with 32'h8001_7FF2; LB at 0x100 -> resp_rdata=32'hFFFF_FFF2, err=00, resp_valid 3 cycles after acceptance. LBU at 0x101 -> 32'h0000_007F.
- Same word: LH at 0x102 -> 32'hFFFF_8001; LHU at 0x102 -> 32'h0000_8001; LW at 0x100 -> 32'h8001_7FF2.
- SB of 32'h0000_00AB to 0x203, then LW at 0x200 -> byte 3 = AB, other bytes unchanged. During the SB issue cycle: mem_we=1, mem_store_type=01, mem_store_offset=11, mem_adr=0x80.
- LH at 0x101 -> err=01 one cycle after acceptance, mem_we never asserted; funct3=011 load -> err=10.
- Hold resp_ready=0 for 5 cycles on a load: resp_valid and resp_rdata stay stable and req_ready=0. Assert RST while in DATA: next cycle resp_valid=0, req_ready=1 after RST drops.
- With LSU_RANGE_CHK_EN and MEM_AW=16: LW at 0x0004_0000 -> err=11, no RAM access. Without the macro: normal access at mem_adr=0x0001_0000.
